pulse_hs_tx: RTL
================

# pulse_hs_tx

Source-side transmitter for a two-phase (toggle) req/ack pulse-crossing protocol. Converts single-cycle event pulses in the `clk_i` domain into toggles on `req_o`. Never launches a new toggle until the far end has returned a matching toggle on `ack_i`, so closely spaced pulses are queued in a pending counter instead of being lost. Sits in the sending domain; the receiving domain recovers pulses from `req_o` and returns `ack_i` as a level.

## Interface
Parameters:
- CNT_W, 4, width of the pending-pulse counter; the counter holds at most 2^CNT_W-1 queued pulses.
- SYNC_STAGES, 2, number of flops synchronizing `ack_i`; legal range 2..4.

Ports:
- clk_i  in  1  sending-domain clock; the only clock in the block.
- rstn_i  in  1  reset, asynchronous, active-low.
- puls_i  in  1  event pulse; every cycle it is high counts as one event.
- ack_i  in  1  acknowledge toggle level from the receiving domain; asynchronous to `clk_i`.
- clr_ovf_i  in  1  clears `ovf_o`.
- req_o  out  1  request toggle level to the receiving domain; driven directly from a flop.
- busy_o  out  1  high while a handshake is outstanding or pulses are pending.
- pend_o  out  CNT_W  current pending-pulse count.
- ovf_o  out  1  sticky flag: a pulse was dropped.

## Operation
- `ack_i` passes through SYNC_STAGES flops to produce `ack_s`. Nothing else samples `ack_i`.
- The FSM state (enum) has two values:
  - IDLE: no handshake outstanding.
  - WAIT_ACK: `req_o` has toggled and `ack_s` has not yet matched it.
- launch = (state==IDLE) && (pend!=0 || puls_i).
- On launch:
  - `req_o` toggles.
  - The state moves to WAIT_ACK.
- The state moves from WAIT_ACK to IDLE when `ack_s == req_o`.
- pend_next = pend + puls_i − launch, subject to these rules:
  - Overflow: if puls_i && !launch && pend == 2^CNT_W−1, the pulse is dropped, pend holds, and `ovf_o` is set.
  - A pulse arriving in the same cycle as a launch with pend at maximum is not an overflow; net change is 0.
  - A pulse in IDLE with pend==0 launches directly; pend stays 0.
- `ovf_o` is sticky and cleared by `clr_ovf_i`. If set and clear occur in the same cycle, set wins.
- busy_o = (state==WAIT_ACK) || (pend!=0). This output is combinational from flops.
- Reset values: `req_o`=0, `busy_o`=0, `pend_o`=0, `ovf_o`=0, state=IDLE, all sync flops 0.
- Reset mid-handshake discards queued pulses and the outstanding toggle. Integration rule: the receiving end shares `rstn_i` so both toggle levels restart at 0.

## Timing
- `puls_i` high in cycle c with state IDLE: `req_o` toggles at the edge ending cycle c and is visible in cycle c+1.
- `ack_i` toggling before edge e: `ack_s` reflects it after SYNC_STAGES edges. The state returns to IDLE one edge later; the next launch can occur one further edge later.
- Minimum launch spacing from the sending side is therefore SYNC_STAGES+2 `clk_i` cycles plus receiver round-trip.
- Sustained throughput is one pulse per handshake. The queue absorbs bursts up to 2^CNT_W−1 events.
- An `ack_s` toggle observed in IDLE (a spurious ack) is ignored. The next launch realigns: `req_o` toggles, and WAIT_ACK waits for a match.
- `pend_o` updates on the same edge as the `req_o` toggle. It never wraps; it saturates with overflow flagged.

## Structure
- Package `pulse_hs_pkg`:
  - `hs_state_e` enum {IDLE, WAIT_ACK}.
  - Localparam defaults CNT_W_DEF=4 and SYNC_STAGES_DEF=2.
- Sub-module `ack_nsync`: parameterized N-stage level synchronizer (clk, rstn, d, q), reset to 0. The same module is reused by the receiving side.
- Top-level RTL contains the FSM, the pending counter, the overflow logic and the toggle flop.

## Test plan
- Reset then single pulse: `puls_i`=1 for one cycle → `req_o` 0→1 next cycle, `busy_o`=1. Loopback ack with 3-cycle delay → `busy_o`=0 after sync latency, `pend_o`=0.
- Burst of 5 back-to-back pulses, ack loopback delay 4 → exactly 5 `req_o` toggles, each only after `ack_s` matches; `pend_o` peaks at 4; `ovf_o`=0.
- CNT_W=2, 6 consecutive pulses with ack held → 1 launch, `pend_o`=3, `ovf_o`=1. Then `clr_ovf_i` → `ovf_o`=0; after acks, exactly 4 total toggles.
- Pulse coincident with launch at pend=max → no overflow; `pend_o` unchanged.
- `rstn_i` asserted during WAIT_ACK with pend=2 → all outputs 0 immediately and asynchronously; after release, a new pulse launches normally.
- Simultaneous `clr_ovf_i` and an overflowing pulse → `ovf_o` remains 1.

Source files
------------

// File: rtl/pulse_hs_pkg.sv
// Shared types and parameter defaults for the two-phase (toggle) pulse handshake.
package pulse_hs_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } hs_state_e;

  localparam int CNT_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pulse_hs_tx_if.sv
// Handshake bundle between pulse_hs_tx (master) and its surroundings (slave).
interface pulse_hs_tx_if
  import pulse_hs_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             puls_i;
  logic             ack_i;
  logic             clr_ovf_i;
  logic             req_o;
  logic             busy_o;
  logic [CNT_W-1:0] pend_o;
  logic             ovf_o;

  modport master (
    input  puls_i, ack_i, clr_ovf_i,
    output req_o, busy_o, pend_o, ovf_o
  );

  modport slave (
    output puls_i, ack_i, clr_ovf_i,
    input  req_o, busy_o, pend_o, ovf_o
  );

endinterface

// File: rtl/ack_nsync.sv
// N-stage level synchronizer with async active-low reset to 0.
// Shared with the receiving side of the handshake.
module ack_nsync
  import pulse_hs_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_hs_tx.sv
// Source side of a toggle req/ack pulse crossing: queues event pulses and
// launches one req toggle per completed handshake.
module pulse_hs_tx
  import pulse_hs_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic           clk_i,
  input logic           rstn_i,
  pulse_hs_tx_if.master hs
);

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hs_state_e        state_q;
  hs_state_e        state_d;
  logic             req_q;
  logic             req_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_d;
  logic             ack_s;
  logic             launch;
  logic             drop;

  ack_nsync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .d_i   (hs.ack_i),
    .q_o   (ack_s)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q & ~hs.clr_ovf_i;
    launch  = 1'b0;
    drop    = 1'b0;

    // An ack seen while IDLE is ignored; only the toggle we launched is awaited.
    case (state_q)
      IDLE: begin
        if (hs.puls_i || (pend_q != '0)) begin
          launch  = 1'b1;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pulse coinciding with a launch nets to zero, so it can never overflow.
    if (hs.puls_i && !launch) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (launch && !hs.puls_i) begin
      pend_d = pend_q - PEND_ONE;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign hs.req_o  = req_q;
  assign hs.busy_o = (state_q == WAIT_ACK) || (pend_q != '0);
  assign hs.pend_o = pend_q;
  assign hs.ovf_o  = ovf_q;

endmodule
